// File: rtl/serial_parity_engine.sv
// serial_parity_engine
//   Bit-serial parity generator/checker for the UART Tx and Rx datapaths.
//   Parity is accumulated one bit at a time as data streams past. In check
//   mode the received parity bit is sampled after the data bits and compared
//   against the computed one.
//
// Handshake: a bit is consumed on a rising Clock edge where BitValid=1 and
//   the engine is in ACCUM or PARITY. There is no back-pressure; idle cycles
//   (BitValid=0) may appear anywhere in a frame.
//
// Ports
//   Clock        system clock, rising edge
//   Reset        asynchronous, active-high reset
//   Start        one-cycle frame start pulse (honoured in IDLE only)
//   Check        sampled at Start: 0 = generate, 1 = check
//   ParityType   sampled at Start: 000 none, 001 odd, 010 even, 011 mark,
//                100 space, others none
//   DataLen      sampled at Start: data bits per frame, clamped 5..DATA_WIDTH
//   BitValid     BitIn qualifier
//   BitIn        serial data bit, or received parity bit in PARITY
//   Abort        synchronous cancel, frame dropped
//   Busy         high in every state except IDLE
//   ParityEn     latched: mode is not none
//   ParityOut    computed parity bit, held until the next Start
//   ParityError  check mode mismatch flag, held until the next Start
//   Done         one-cycle completion pulse
//   StateDbg     current FSM state (debug visibility)
module serial_parity_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Check,
  input  logic [2:0]       ParityType,
  input  logic [LEN_W-1:0] DataLen,
  input  logic             BitValid,
  input  logic             BitIn,
  input  logic             Abort,
  output logic             Busy,
  output logic             ParityEn,
  output logic             ParityOut,
  output logic             ParityError,
  output logic             Done,
  output logic [1:0]       StateDbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [2:0] MODE_NONE  = 3'b000;
  localparam logic [2:0] MODE_ODD   = 3'b001;
  localparam logic [2:0] MODE_EVEN  = 3'b010;
  localparam logic [2:0] MODE_MARK  = 3'b011;
  localparam logic [2:0] MODE_SPACE = 3'b100;

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(5);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_WIDTH);

  state_t           stateQ, stateNext;
  logic             checkQ;
  logic [2:0]       modeQ;
  logic [LEN_W-1:0] lenQ;
  logic             accQ;
  logic [LEN_W-1:0] countQ;

  logic [2:0]       modeIn;
  logic [LEN_W-1:0] lenIn;
  logic             accNext;
  logic [LEN_W-1:0] countNext;
  logic             lastBit;

  function automatic logic parityBit(input logic [2:0] mode, input logic acc);
    case (mode)
      MODE_ODD:  parityBit = ~acc;
      MODE_EVEN: parityBit = acc;
      MODE_MARK: parityBit = 1'b1;
      default:   parityBit = 1'b0;
    endcase
  endfunction

  // Reserved ParityType codes collapse to none so the rest of the logic
  // only ever sees the five legal modes.
  always_comb begin
    modeIn = MODE_NONE;
    if (ParityType == MODE_ODD || ParityType == MODE_EVEN ||
        ParityType == MODE_MARK || ParityType == MODE_SPACE)
      modeIn = ParityType;
  end

  always_comb begin
    lenIn = DataLen;
    if (DataLen < MIN_LEN)      lenIn = MIN_LEN;
    else if (DataLen > MAX_LEN) lenIn = MAX_LEN;
  end

  // countQ stops at lenQ (<= DATA_WIDTH), so the increment cannot wrap.
  assign accNext   = accQ ^ BitIn;
  assign countNext = countQ + LEN_W'(1);
  assign lastBit   = BitValid && (countNext == lenQ);

  // Next-state logic
  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      IDLE:   if (Start) stateNext = ACCUM;
      ACCUM:  if (lastBit)
                stateNext = (checkQ && modeQ != MODE_NONE) ? PARITY : DONE;
      PARITY: if (BitValid) stateNext = DONE;
      DONE:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (Abort) stateNext = IDLE;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) stateQ <= IDLE;
    else       stateQ <= stateNext;
  end

  // Datapath: frame config, accumulator, counter and result flags
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      checkQ      <= 1'b0;
      modeQ       <= MODE_NONE;
      lenQ        <= '0;
      accQ        <= 1'b0;
      countQ      <= '0;
      ParityEn    <= 1'b0;
      ParityOut   <= 1'b0;
      ParityError <= 1'b0;
    end else if (Abort) begin
      // ParityOut deliberately survives an abort.
      ParityError <= 1'b0;
    end else begin
      case (stateQ)
        IDLE: if (Start) begin
          checkQ      <= Check;
          modeQ       <= modeIn;
          lenQ        <= lenIn;
          accQ        <= 1'b0;
          countQ      <= '0;
          ParityError <= 1'b0;
          ParityEn    <= (modeIn != MODE_NONE);
        end
        ACCUM: if (BitValid) begin
          accQ   <= accNext;
          countQ <= countNext;
          if (lastBit) ParityOut <= parityBit(modeQ, accNext);
        end
        PARITY: if (BitValid) ParityError <= (BitIn != ParityOut);
        default: ;
      endcase
    end
  end

  assign Busy     = (stateQ != IDLE);
  assign Done     = (stateQ == DONE);
  assign StateDbg = stateQ;

endmodule

// File: doc/serial_parity_engine.md
Name: serial_parity_engine

Overview:
Bit-serial parity generator/checker for the UART Tx and Rx datapaths. It is the successor to the fixed 8-bit combinational parity unit. Data width is parametrised, frame length is selectable at run time, and mark and space modes are added. Parity is accumulated as bits stream past, so no parallel data register is needed. In check mode it also samples the received parity bit and flags a mismatch.

Parameters:
DATA_WIDTH, 8, maximum data bits per frame (5..16)
LEN_W, 5, width of DataLen input; must hold DATA_WIDTH

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  one-cycle pulse; begins a frame (honoured in IDLE only)
Check  input  1  sampled at Start: 0 = generate (Tx), 1 = check (Rx)
ParityType  input  3  sampled at Start: 000 none, 001 odd, 010 even, 011 mark, 100 space, others = none
DataLen  input  LEN_W  sampled at Start: data bits in frame; clamped to 5..DATA_WIDTH
BitValid  input  1  BitIn qualifier; gaps allowed
BitIn  input  1  serial data bit, or the received parity bit in PARITY state
Abort  input  1  synchronous cancel; frame dropped
Busy  output  1  high in every state except IDLE
ParityEn  output  1  latched: 1 when the mode is not none (Tx inserts a parity bit)
ParityOut  output  1  computed parity bit; held until the next Start
ParityError  output  1  check mode: received parity differs from expected; held until the next Start
Done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, high):
  - State goes to IDLE.
  - Busy, ParityEn, ParityOut, ParityError, Done all = 0.
  - Accumulator and counter = 0.
- States: IDLE, ACCUM, PARITY, DONE.
- IDLE:
  - Start=1 latches Check, ParityType and the clamped DataLen.
  - Clears accumulator, counter and ParityError.
  - ParityEn = (mode != none). Next state ACCUM.
- ACCUM, each cycle with BitValid=1:
  - acc ^= BitIn; count += 1. Cycles with BitValid=0 leave state unchanged.
  - On the bit where count reaches len, ParityOut is registered from the final acc value:
    - odd = ~acc
    - even = acc
    - mark = 1
    - space = 0
    - none = 0
  - Next state is PARITY if Check=1 and mode != none; otherwise DONE.
- PARITY: on BitValid=1, ParityError <= (BitIn != ParityOut); next state DONE.
- DONE: Done=1 for exactly one cycle, then IDLE. ParityOut and ParityError stay valid and hold until the next accepted Start.
- Latency: Done is asserted the cycle after the last consumed bit (last data bit in generate mode, parity bit in check mode). ParityOut is valid no later than Done.
- Start outside IDLE (including during the DONE cycle) is ignored; latched config is unaffected.
- Abort=1 in any state returns to IDLE next cycle:
  - Done is not pulsed; ParityError is cleared; ParityOut is unchanged.
  - Abort and Start in the same IDLE cycle: Abort wins, no frame starts.
- Clamping: DataLen < 5 gives 5; DataLen > DATA_WIDTH gives DATA_WIDTH. The counter never wraps.
- An async Reset mid-frame drops the frame immediately; no Done is produced.
- Bit order is irrelevant to parity; any order is accepted.

Test Plan:
- Generate, odd, len 8, bits of 0xA5 (four ones), BitValid continuous -> Done on cycle 9 after Start, ParityOut=1, ParityEn=1, ParityError=0.
- Generate, even, len 8, 0x07 with BitValid gaps inserted -> ParityOut=1; Done one cycle after the 8th valid bit; Busy high throughout.
- Check, even, len 8, 0x07 then parity bit 0 -> ParityError=1, Done. Repeat with parity bit 1 -> ParityError=0.
- Length/mode boundaries:
  - Generate, odd, DataLen=5, bits 1,0,1,1,0 -> ParityOut=0.
  - DataLen=2 -> clamped to 5; Done only after 5 bits.
  - Mark -> ParityOut=1 and space -> ParityOut=0, regardless of data.
- Check, ParityType=000 (and 111), len 8 -> PARITY skipped, Done after 8 bits, ParityEn=0, ParityError=0.
- Abort/Reset:
  - Abort after 4 bits -> IDLE, no Done.
  - Start during DONE is ignored.
  - Reset asserted mid-ACCUM -> all outputs 0 immediately.
  - A fresh frame after Reset completes correctly.
